// File: rtl/stripes_slice_ctrl.sv
// Job sequencer for one Stripes filter slice: brick fetch, P-cycle bit-serial
// drive, pipe drain, then a backpressured walk of the output window mux.
module stripes_slice_ctrl #(
    parameter int Tw    = 16,
    parameter int SEL_W = 4,
    parameter int CNT_W = 8,
    parameter int DRAIN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    output logic             o_ready,
    input  logic [4:0]       i_precision,
    input  logic [CNT_W-1:0] i_num_bricks,
    input  logic             i_maxpool,
    input  logic             i_abort,
    input  logic             i_in_valid,
    output logic             o_in_pop,
    output logic [Tw-1:0]    o_load,
    output logic             o_first_cycle,
    output logic [4:0]       o_precision,
    output logic             o_maxpool,
    output logic [SEL_W-1:0] o_mux_sel,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [2:0]       o_state
);

    // Handshakes: a brick moves when o_in_pop=1, which is only raised in a
    // cycle where i_in_valid=1; a window moves when o_out_valid=1 and
    // i_out_ready=1 in the same cycle. Neither side may retract mid-cycle.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SERIAL = 3'd2,
        S_DRAIN  = 3'd3,
        S_OUTPUT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           state, state_nx;
    logic [4:0]       prec_q;
    logic             mp_q;
    logic [CNT_W-1:0] bricks_q;
    logic [CNT_W-1:0] brick_cnt;
    logic [4:0]       bit_cnt;
    logic [3:0]       drain_cnt;
    logic [SEL_W-1:0] sel_q;

    logic             abort_job;
    logic             last_bit;
    logic             last_brick;
    logic             drain_end;
    logic             last_win;
    logic [4:0]       prec_in;
    logic [CNT_W-1:0] bricks_in;

    assign abort_job  = i_abort && (state != S_IDLE);
    assign last_bit   = (bit_cnt == 5'd0);
    assign last_brick = ((brick_cnt + CNT_W'(1)) == bricks_q);
    assign drain_end  = (drain_cnt == 4'd0);
    assign last_win   = (sel_q == SEL_W'(Tw - 1));

    // Out-of-range precision falls back to full 16-bit serial processing.
    assign prec_in   = ((i_precision == 5'd0) || (i_precision > 5'd16)) ? 5'd16 : i_precision;
    assign bricks_in = (i_num_bricks == '0) ? CNT_W'(1) : i_num_bricks;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (i_start) state_nx = S_LOAD;
            S_LOAD:   if (i_in_valid) state_nx = S_SERIAL;
            S_SERIAL: if (last_bit) state_nx = last_brick ? S_DRAIN : S_LOAD;
            S_DRAIN:  if (drain_end) state_nx = S_OUTPUT;
            S_OUTPUT: if (i_out_ready && last_win) state_nx = S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
        if (abort_job) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prec_q    <= '0;
            mp_q      <= 1'b0;
            bricks_q  <= '0;
            brick_cnt <= '0;
            bit_cnt   <= '0;
            drain_cnt <= '0;
            sel_q     <= '0;
        end else if (abort_job) begin
            brick_cnt <= '0;
            bit_cnt   <= '0;
            drain_cnt <= '0;
            sel_q     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (i_start) begin
                        prec_q    <= prec_in;
                        mp_q      <= i_maxpool;
                        bricks_q  <= bricks_in;
                        brick_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (i_in_valid) bit_cnt <= prec_q - 5'd1;
                end
                S_SERIAL: begin
                    if (last_bit) begin
                        brick_cnt <= brick_cnt + CNT_W'(1);
                        if (last_brick) drain_cnt <= 4'(DRAIN - 1);
                    end else begin
                        bit_cnt <= bit_cnt - 5'd1;
                    end
                end
                S_DRAIN: begin
                    if (drain_end) sel_q <= '0;
                    else drain_cnt <= drain_cnt - 4'd1;
                end
                S_OUTPUT: begin
                    if (i_out_ready && !last_win) sel_q <= sel_q + SEL_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Pop is qualified by i_in_valid in the same cycle so a stalled source
    // simply holds the sequencer in LOAD.
    assign o_in_pop      = (state == S_LOAD) && i_in_valid && !i_abort;
    assign o_load        = {Tw{o_in_pop}};
    assign o_first_cycle = (state == S_SERIAL) && (brick_cnt == '0) && (bit_cnt == prec_q - 5'd1);
    assign o_precision   = prec_q;
    assign o_maxpool     = mp_q;
    assign o_mux_sel     = sel_q;
    assign o_out_valid   = (state == S_OUTPUT);
    assign o_ready       = (state == S_IDLE);
    assign o_busy        = (state != S_IDLE);
    assign o_done        = (state == S_DONE);
    assign o_state       = state;

endmodule

// File: tb/tb_stripes_slice_ctrl.sv
// Bench for stripes_slice_ctrl: directed vector table, hand-written corner
// sequences and randomized jobs against a cycle-timeline reference model.
module tb_stripes_slice_ctrl;
  localparam int TW    = 16;
  localparam int SEL_W = 4;
  localparam int CNT_W = 8;
  localparam int DRAIN = 2;
  localparam int MAXC  = 512;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_start;
  logic             o_ready;
  logic [4:0]       i_precision;
  logic [CNT_W-1:0] i_num_bricks;
  logic             i_maxpool;
  logic             i_abort;
  logic             i_in_valid;
  logic             o_in_pop;
  logic [TW-1:0]    o_load;
  logic             o_first_cycle;
  logic [4:0]       o_precision;
  logic             o_maxpool;
  logic [SEL_W-1:0] o_mux_sel;
  logic             o_out_valid;
  logic             i_out_ready;
  logic             o_busy;
  logic             o_done;
  logic [2:0]       dbg_state;

  always #5 clk = ~clk;

  stripes_slice_ctrl #(.Tw(TW), .SEL_W(SEL_W), .CNT_W(CNT_W), .DRAIN(DRAIN)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .o_ready(o_ready),
    .i_precision(i_precision), .i_num_bricks(i_num_bricks), .i_maxpool(i_maxpool),
    .i_abort(i_abort), .i_in_valid(i_in_valid), .o_in_pop(o_in_pop), .o_load(o_load),
    .o_first_cycle(o_first_cycle), .o_precision(o_precision), .o_maxpool(o_maxpool),
    .o_mux_sel(o_mux_sel), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_busy(o_busy), .o_done(o_done), .o_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic        vld_a[MAXC];
  logic        rdy_a[MAXC];
  logic [15:0] e_load[MAXC];
  logic        e_first[MAXC];
  logic        e_ov[MAXC];
  logic [3:0]  e_sel[MAXC];
  int          m_done;
  int          m_done_seen;
  int          m_loads;
  int          m_last;
  logic [4:0]  m_prec_seen;

  typedef struct {
    int p; int b; bit mp;
    int vlo_s; int vlo_n; int rlo_s; int rlo_n;
    int glitch; bit abort0;
    int exp_done; int exp_loads; int exp_last; int exp_prec;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [15:0] ld, input logic pop, input logic first,
                                       input logic ov, input logic [3:0] sel, input logic done,
                                       input logic busy, input logic rdy, input logic [4:0] prec,
                                       input logic mp);
    return {prec, mp, ld, pop, first, ov, sel, done, busy, rdy};
  endfunction

  // Timeline model: walks the job forward in cycles from the start cycle.
  task automatic model(input int p_raw, input int b_raw, input bit mp);
    int p, b, t;
    p = (p_raw == 0 || p_raw > 16) ? 16 : p_raw;
    b = (b_raw == 0) ? 1 : b_raw;
    for (int i = 0; i < MAXC; i++) begin
      e_load[i] = '0; e_first[i] = 1'b0; e_ov[i] = 1'b0; e_sel[i] = '0;
    end
    t = 1;
    for (int br = 0; br < b; br++) begin
      while (!vld_a[t]) t++;
      e_load[t] = 16'hFFFF;
      if (br == 0) e_first[t+1] = 1'b1;
      t += 1 + p;
    end
    t += DRAIN;
    for (int w = 0; w < TW; w++) begin
      while (!rdy_a[t]) begin
        e_ov[t] = 1'b1; e_sel[t] = w[3:0]; t++;
      end
      e_ov[t] = 1'b1; e_sel[t] = w[3:0]; t++;
    end
    exp_q.delete();
    for (int c = 0; c <= t; c++)
      exp_q.push_back(pack(e_load[c], e_load[c][0], e_first[c], e_ov[c], e_sel[c], c == t,
                           c >= 1, c == 0, (c >= 1) ? 5'(p) : 5'd0, (c >= 1) ? mp : 1'b0));
    m_done = t;
  endtask

  // Entered and left just after a rising edge; cycle 0 is the start cycle.
  task automatic run_case(input string tag, input int p, input int b, input bit mp,
                          input int glitch, input bit abort0);
    int c;
    logic [31:0] e, a;
    model(p, b, mp);
    m_loads = 0; m_last = -1; m_done_seen = -1; m_prec_seen = '0;
    c = 0;
    while (exp_q.size() > 0) begin
      i_start = (c == 0) || (c == glitch);
      i_abort = (c == 0) && abort0;
      if (c == 0) begin
        i_precision = p[4:0]; i_num_bricks = b[CNT_W-1:0]; i_maxpool = mp;
      end else begin
        i_precision = 5'($urandom_range(0, 31));
        i_num_bricks = CNT_W'($urandom_range(0, 255));
        i_maxpool = 1'($urandom_range(0, 1));
      end
      i_in_valid = vld_a[c];
      i_out_ready = rdy_a[c];
      @(negedge clk);
      e = exp_q.pop_front();
      a = pack(o_load, o_in_pop, o_first_cycle, o_out_valid, e[7] ? o_mux_sel : 4'd0, o_done,
               o_busy, o_ready, e[1] ? o_precision : 5'd0, e[1] ? o_maxpool : 1'b0);
      check($sformatf("%s trace c=%0d", tag, c), a, e);
      if (o_in_pop) begin m_loads++; m_last = c; end
      if (o_done && m_done_seen < 0) begin m_done_seen = c; m_prec_seen = o_precision; end
      @(posedge clk); #1;
      c++;
    end
    i_start = 1'b0;
    i_abort = 1'b0;
  endtask

  task automatic start_nominal();
    i_start = 1'b1; i_precision = 5'd4; i_num_bricks = 8'd2; i_maxpool = 1'b0;
    i_in_valid = 1'b1; i_out_ready = 1'b1; i_abort = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, b, g, dcnt;
    bit mp;
    reset = 1'b0; i_start = 1'b0; i_precision = '0; i_num_bricks = '0; i_maxpool = 1'b0;
    i_abort = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;

    // Reset and quiet idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {o_ready, o_busy, o_load, o_in_pop, o_first_cycle, o_out_valid,
                          o_mux_sel, o_done, o_precision, o_maxpool}, {1'b1, 31'b0});
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("idle_hold %0d", i), {o_ready, o_busy, o_load, o_in_pop, o_first_cycle,
            o_out_valid, o_mux_sel, o_done, o_precision, o_maxpool}, {1'b1, 31'b0});
      @(posedge clk); #1;
    end

    // Directed vector table
    tbl[0] = '{4, 2, 1'b0, 0, 0, 0, 0, -1, 1'b0, 29, 2, 6, 4};
    tbl[1] = '{4, 2, 1'b1, 6, 3, 0, 0, -1, 1'b0, 32, 2, 9, 4};
    tbl[2] = '{4, 2, 1'b0, 0, 0, 18, 3, -1, 1'b0, 32, 2, 6, 4};
    tbl[3] = '{0, 1, 1'b0, 0, 0, 0, 0, -1, 1'b0, 36, 1, 1, 16};
    tbl[4] = '{20, 1, 1'b1, 0, 0, 0, 0, -1, 1'b0, 36, 1, 1, 16};
    tbl[5] = '{4, 0, 1'b0, 0, 0, 0, 0, -1, 1'b0, 24, 1, 1, 4};
    tbl[6] = '{4, 2, 1'b0, 0, 0, 0, 0, 5, 1'b0, 29, 2, 6, 4};
    tbl[7] = '{4, 2, 1'b0, 0, 0, 0, 0, -1, 1'b1, 29, 2, 6, 4};
    tbl[8] = '{1, 3, 1'b0, 0, 0, 0, 0, -1, 1'b0, 25, 3, 5, 1};
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < MAXC; c++) begin
        vld_a[c] = !(c >= tbl[k].vlo_s && c < tbl[k].vlo_s + tbl[k].vlo_n);
        rdy_a[c] = !(c >= tbl[k].rlo_s && c < tbl[k].rlo_s + tbl[k].rlo_n);
      end
      run_case($sformatf("vec%0d", k), tbl[k].p, tbl[k].b, tbl[k].mp, tbl[k].glitch, tbl[k].abort0);
      check($sformatf("vec%0d done_cycle", k), m_done_seen, tbl[k].exp_done);
      check($sformatf("vec%0d load_count", k), m_loads, tbl[k].exp_loads);
      check($sformatf("vec%0d last_load", k), m_last, tbl[k].exp_last);
      check($sformatf("vec%0d prec", k), {27'b0, m_prec_seen}, tbl[k].exp_prec);
    end

    // Abort in SERIAL
    start_nominal();
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_abort = 1'b1;
    @(negedge clk);
    check("abort_pre_busy", {31'b0, o_busy}, 32'd1);
    @(posedge clk); #1;
    i_abort = 1'b0;
    @(negedge clk);
    check("abort_idle", {o_ready, o_busy, o_load, o_in_pop, o_done},
          {1'b1, 1'b0, 16'h0, 1'b0, 1'b0});
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (o_done || o_busy) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    @(posedge clk); #1;

    // Reset in OUTPUT
    start_nominal();
    repeat (14) begin @(posedge clk); #1; end
    @(negedge clk);
    check("rst_pre_out", {31'b0, o_out_valid}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_mid_out", {o_out_valid, o_ready, o_busy, o_done}, 4'b0100);
    @(posedge clk); #1;
    reset = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (o_done || o_busy) dcnt++;
      @(posedge clk); #1;
    end
    check("rst_no_done", dcnt, 0);

    // Randomized jobs against the model
    for (int j = 0; j < 25; j++) begin
      p = $urandom_range(0, 20);
      b = $urandom_range(0, 4);
      mp = 1'($urandom_range(0, 1));
      for (int c = 0; c < MAXC; c++) begin
        vld_a[c] = (c < 200) ? ($urandom_range(0, 3) != 0) : 1'b1;
        rdy_a[c] = (c < 200) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      g = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 20)) : -1;
      run_case($sformatf("rand%0d", j), p, b, mp, g, 1'($urandom_range(0, 1)));
      check($sformatf("rand%0d done_cycle", j), m_done_seen, m_done);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
